// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead circular byte buffer behind the UART receiver.
// Optional sticky overrun flag: define UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_tick,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  input  logic              clr_overrun,
  output logic              overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              pop_ok;
  logic              wr_ok;
  logic              drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0])
              && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign almost_full = (level >= AF_LVL);
  assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // A pop frees the slot a same-cycle write needs when full.
  assign pop_ok = rd_en & ~empty;
  assign wr_ok  = wr_tick & (~full | pop_ok);
  assign drop   = wr_tick & ~wr_ok;

  // Pointer next-state: each advances by one on an accepted access.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the buffer at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Sticky drop flag; a new drop beats a coincident clear.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    if (drop)        ovr_d = 1'b1;
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovr_q <= 1'b0;
    else          ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`else
  logic unused_ovr;

  assign unused_ovr = clr_overrun | drop;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the receive byte buffer.
// Overrun expectations follow UART_RX_FIFO_OVERRUN_EN.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_tick = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       clr_overrun = 1'b0;
  logic       overrun;

  int nvec = 0;
  int nerr = 0;

`ifdef UART_RX_FIFO_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  uart_rx_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_tick     (wr_tick),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .clr_overrun (clr_overrun),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d,
                     input logic r, input logic c);
    wr_tick = w;
    wr_data = d;
    rd_en = r;
    clr_overrun = c;
    @(posedge clk);
    #1;
    wr_tick = 1'b0;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_b;
  logic [7:0] cnt;

  initial begin
    // reset state
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // basic three-byte write / pop
    cyc(1, 8'h55, 0, 0);
    cyc(1, 8'hA3, 0, 0);
    cyc(1, 8'h0F, 0, 0);
    chk("b_level3", 32'(level), 32'd3);
    chk("b_head55", 32'(rd_data), 32'h55);
    chk("b_nempty", 32'(empty), 32'd0);
    cyc(0, 8'h00, 1, 0);
    chk("b_headA3", 32'(rd_data), 32'hA3);
    cyc(0, 8'h00, 1, 0);
    chk("b_head0F", 32'(rd_data), 32'h0F);
    cyc(0, 8'h00, 1, 0);
    chk("b_empty", 32'(empty), 32'd1);
    chk("b_level0", 32'(level), 32'd0);
    cyc(0, 8'h00, 1, 0);
    chk("b_rd_on_empty", 32'(level), 32'd0);

    // fill to full, watching thresholds
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      chk("f_level", 32'(level), 32'(i + 1));
      chk("f_af", 32'(almost_full), 32'((i + 1) >= 12));
      chk("f_full", 32'(full), 32'((i + 1) == 16));
    end
    chk("f_ovr_pre", 32'(overrun), 32'd0);
    cyc(1, 8'hFF, 0, 0);
    chk("f_drop_lvl", 32'(level), 32'd16);
    chk("f_drop_head", 32'(rd_data), 32'h00);
    chk("f_ovr", 32'(overrun), 32'(OVR));

    // write + pop while full
    cyc(1, 8'h99, 1, 0);
    chk("wp_full_lvl", 32'(level), 32'd16);
    chk("wp_full_flag", 32'(full), 32'd1);
    chk("wp_full_head", 32'(rd_data), 32'h01);
    chk("wp_full_ovr", 32'(overrun), 32'(OVR));

    // clear coincident with a drop, then clear alone
    cyc(1, 8'hEE, 0, 1);
    chk("clr_drop_ovr", 32'(overrun), 32'(OVR));
    chk("clr_drop_lvl", 32'(level), 32'd16);
    cyc(0, 8'h00, 0, 1);
    chk("clr_ovr", 32'(overrun), 32'd0);

    // drain: 01..0F then 99
    for (int i = 1; i < 17; i++) begin
      exp_b = (i == 16) ? 8'h99 : 8'(i);
      chk("d_data", 32'(rd_data), 32'(exp_b));
      cyc(0, 8'h00, 1, 0);
    end
    chk("d_empty", 32'(empty), 32'd1);
    chk("d_level", 32'(level), 32'd0);

    // write + pop while empty
    cyc(1, 8'h42, 1, 0);
    chk("we_level", 32'(level), 32'd1);
    chk("we_head", 32'(rd_data), 32'h42);
    cyc(0, 8'h00, 1, 0);
    chk("we_empty", 32'(empty), 32'd1);

    // wrap: 40 write/pop pairs, level held at 2
    cnt = 8'h20;
    for (int i = 0; i < 2; i++) begin
      q.push_back(cnt);
      cyc(1, cnt, 0, 0);
      cnt++;
    end
    for (int i = 0; i < 40; i++) begin
      chk("w_data", 32'(rd_data), 32'(q[0]));
      q.push_back(cnt);
      void'(q.pop_front());
      cyc(1, cnt, 1, 0);
      cnt++;
      chk("w_level", 32'(level), 32'd2);
      chk("w_flags", 32'({full, empty}), 32'd0);
    end
    while (q.size() > 0) begin
      chk("w_tail", 32'(rd_data), 32'(q[0]));
      void'(q.pop_front());
      cyc(0, 8'h00, 1, 0);
    end
    chk("w_empty", 32'(empty), 32'd1);

    // asynchronous reset with data held
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hB0 + i), 0, 0);
    chk("r_level5", 32'(level), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("r_empty", 32'(empty), 32'd1);
    chk("r_level0", 32'(level), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 8'h7E, 0, 0);
    chk("r_post_lvl", 32'(level), 32'd1);
    chk("r_post_head", 32'(rd_data), 32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each completed frame on the receiver's one-cycle done strobe, stores it in a circular buffer, and presents the oldest byte to the host/bus side through a show-ahead read port. Provides occupancy, empty/full/almost-full status and, optionally, a sticky overrun indication for dropped bytes.

## Interface
- DATA_W, 8, width of each stored word; matches receiver data bits
- ADDR_W, 4, address bits; depth = 2**ADDR_W words (default 16)
- AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL; legal range 1..2**ADDR_W

- clk  input  1  system clock, same domain as receiver
- reset_n  input  1  reset, asynchronous, active-low
- wr_tick  input  1  write strobe; connect to receiver rx_done_tick (one cycle per byte)
- wr_data  input  DATA_W  byte to store; connect to receiver rx_dout, sampled when wr_tick=1
- rd_en  input  1  pop request; consumes head word at clock edge
- rd_data  output  DATA_W  head word (oldest), valid whenever empty=0
- empty  output  1  no words stored
- full  output  1  2**ADDR_W words stored
- almost_full  output  1  level >= AF_LEVEL
- level  output  ADDR_W+1  current word count, 0..2**ADDR_W
- clr_overrun  input  1  clears overrun flag (see Configuration)
- overrun  output  1  sticky: a write was dropped (see Configuration)

## Operation
- Storage: 2**ADDR_W x DATA_W register array; write and read pointers ADDR_W+1 bits wide, low ADDR_W bits index, MSB is wrap bit.
- empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ; level = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Write accepted when wr_tick=1 and (full=0 or pop accepted same cycle): mem[wr_ptr] <= wr_data, wr_ptr += 1.
- Pop accepted when rd_en=1 and empty=0: rd_ptr += 1. rd_en while empty is ignored, no pointer change, no error.
- Write while full with no accepted pop: word discarded, pointers unchanged, FIFO contents intact.
- Simultaneous write and pop, non-empty non-full: both occur, level unchanged.
- Simultaneous write and pop when full: pop frees slot, write accepted, level stays 2**ADDR_W.
- Simultaneous write and pop when empty: write accepted, pop ignored, level becomes 1.
- Pointers wrap naturally from all-ones to zero; no special handling.
- rd_data = mem[rd_ptr[ADDR_W-1:0]] combinationally (show-ahead); value undefined-but-stable when empty; bench must not check it while empty=1.

## Timing
- Reset (asynchronous, reset_n=0): wr_ptr=0, rd_ptr=0, overrun=0; hence empty=1, full=0, almost_full=0, level=0. Array contents not reset. Reset mid-operation discards all stored words immediately.
- Write latency: byte strobed at edge N visible at rd_data (if FIFO was empty) and reflected in empty/level after edge N, i.e. in cycle N+1.
- Pop: rd_data advances to next word in the cycle after the accepted rd_en edge.
- All status outputs are registered-pointer derived; no combinational path from wr_tick/rd_en to any output.
- wr_tick assumed one cycle wide; consecutive-cycle strobes each write one word.

## Configuration
- Macro UART_RX_FIFO_OVERRUN_EN.
- Defined: overrun sets on any cycle where a write is dropped (wr_tick=1, full=1, no accepted pop); remains set until clr_overrun=1; if set and clear coincide, set wins (overrun stays 1).
- Not defined: overrun tied to 0, clr_overrun ignored; dropped writes still discarded silently. Port list identical in both builds.

## Test plan
- Reset then write 0x55, 0xA3, 0x0F on three strobes -> level=3, rd_data=0x55; pop three times -> 0xA3, 0x0F, then empty=1, level=0.
- Write 16 words 0x00..0x0F (defaults) -> almost_full=1 at level 12, full=1 at 16; 17th write 0xFF dropped, pops return 0x00..0x0F in order; overrun=1 with macro, 0 without.
- Full FIFO, wr_tick and rd_en same cycle with 0x99 -> level stays 16, head advances to 0x01, 0x99 emerges last; overrun unchanged.
- Empty FIFO, wr_tick(0x42) and rd_en same cycle -> level=1, rd_data=0x42 next cycle.
- Wrap: 40 write/pop pairs with incrementing data, level held 1..3 -> output sequence matches input exactly, no spurious full/empty.
- Macro defined: force overrun, assert clr_overrun coincident with another dropped write -> overrun stays 1; clear alone -> overrun=0. Assert reset_n low with level=5 -> empty=1, level=0 immediately.
